// File: rtl/ex_div.sv
// ex_div: 32-bit signed/unsigned iterative divider for the EX stage.
// Handshake: div_start is held high by EX until ready is seen. The block
// accepts only in IDLE. Operands are sampled on the accept edge. After
// completion, result/ready stay valid for as long as div_start stays high.
// annul, and rst even more so, abandons any operation at the next edge.
// Timing: an accept at edge T takes 32 restoring steps at edges T+1..T+32.
// The last step enters DONE, and result/ready register at edge T+33.
// A zero divisor takes the BY_ZERO detour and registers result/ready at T+2.
module ex_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_start,
    input  logic        div_signed,
    input  logic [31:0] div_opdata1,
    input  logic [31:0] div_opdata2,
    input  logic        annul,
    output logic [63:0] result,
    output logic        ready,
    output logic        stallreq
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BY_ZERO = 2'd1,
        ON      = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;

    // {remainder[64:33], spare[32], quotient/dividend[31:0]} working register
    logic [64:0] work_q;
    logic [31:0] divisor_q;
    logic [5:0]  cnt_q;
    logic        neg_q_q;   // negate quotient at the end
    logic        neg_r_q;   // negate remainder at the end

    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [32:0] trial;
    logic [31:0] q_raw;
    logic [31:0] r_raw;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    // Operand magnitudes, trial subtraction and final sign correction
    always_comb begin
        mag1  = (div_signed && div_opdata1[31]) ? (~div_opdata1 + 32'd1) : div_opdata1;
        mag2  = (div_signed && div_opdata2[31]) ? (~div_opdata2 + 32'd1) : div_opdata2;
        trial = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
        q_raw = work_q[31:0];
        r_raw = work_q[64:33];
        q_fix = neg_q_q ? (~q_raw + 32'd1) : q_raw;
        r_fix = neg_r_q ? (~r_raw + 32'd1) : r_raw;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; annul overrides everything below it
    always_comb begin
        state_d = state_q;
        if (annul) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (div_start) begin
                        state_d = (div_opdata2 == 32'd0) ? BY_ZERO : ON;
                    end
                end
                BY_ZERO: state_d = DONE;
                ON: begin
                    if (cnt_q == 6'd31) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (!div_start) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Stall EX while a request is pending and the divider has not finished
    always_comb begin
        stallreq = 1'b0;
        if (!rst && !annul && div_start && (state_q != DONE)) begin
            stallreq = 1'b1;
        end
    end

    // Datapath: operand capture, shift-subtract steps, result publication
    always_ff @(posedge clk) begin
        if (rst) begin
            work_q    <= 65'd0;
            divisor_q <= 32'd0;
            cnt_q     <= 6'd0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            result    <= 64'd0;
            ready     <= 1'b0;
        end else if (annul) begin
            cnt_q  <= 6'd0;
            result <= 64'd0;
            ready  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    result <= 64'd0;
                    ready  <= 1'b0;
                    if (div_start) begin
                        cnt_q <= 6'd0;
                        if (div_opdata2 == 32'd0) begin
                            // Preload the by-zero answer: raw dividend as
                            // remainder, all-ones quotient, no correction.
                            work_q    <= {div_opdata1, 1'b0, 32'hFFFF_FFFF};
                            divisor_q <= 32'd0;
                            neg_q_q   <= 1'b0;
                            neg_r_q   <= 1'b0;
                        end else begin
                            work_q    <= {32'd0, mag1, 1'b0};
                            divisor_q <= mag2;
                            neg_q_q   <= div_signed && (div_opdata1[31] ^ div_opdata2[31]);
                            neg_r_q   <= div_signed && div_opdata1[31];
                        end
                    end
                end
                BY_ZERO: begin
                    ready <= 1'b0;
                end
                ON: begin
                    if (trial[32]) begin
                        work_q <= {work_q[63:0], 1'b0};
                    end else begin
                        work_q <= {trial[31:0], work_q[31:0], 1'b1};
                    end
                    cnt_q <= cnt_q + 6'd1;
                end
                DONE: begin
                    if (div_start) begin
                        result <= {r_fix, q_fix};
                        ready  <= 1'b1;
                    end else begin
                        result <= 64'd0;
                        ready  <= 1'b0;
                    end
                end
                default: begin
                    result <= 64'd0;
                    ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ex_div.md
EX_DIV -- requirements
Module: ex_div

Interface
No parameters; all datapaths are fixed at 32 bits.
REQ-001 clk  input  1  Core clock; all state changes on rising edge.
REQ-002 rst  input  1  Reset: synchronous, active-high; clock clk.
REQ-003 div_start  input  1  EX-stage request: a div/divu instruction is in EX; held high until ready is seen.
REQ-004 div_signed  input  1  1 = div (two's-complement), 0 = divu; sampled with the operands.
REQ-005 div_opdata1  input  32  Dividend; sampled at accept.
REQ-006 div_opdata2  input  32  Divisor; sampled at accept.
REQ-007 annul  input  1  Flush or cancel; aborts any operation in progress.
REQ-008 result  output  64  {remainder[63:32], quotient[31:0]}; registered.
REQ-009 ready  output  1  Result valid; registered.
REQ-010 stallreq  output  1  Pipeline stall request to the stall controller; combinational.

Function
REQ-011 The block SHALL implement four states: IDLE, BY_ZERO, ON and DONE.
REQ-012 IDLE: the block SHALL accept an operation when div_start=1 and annul=0, latching the operands and div_signed.
- Divisor == 0 -> next state BY_ZERO.
- Otherwise -> next state ON, with the iteration counter cleared to 0.
REQ-013 Signed operation: the block SHALL divide the magnitudes |op1| and |op2|; the two input sign bits SHALL be latched for post-correction.
REQ-014 ON: the block SHALL perform one restoring shift-subtract step per cycle on a 65-bit {remainder, dividend} register. After exactly 32 steps it SHALL enter DONE.
REQ-015 Latency: with accept sampled at edge T, ready SHALL be 1 after edge T+33 (ON steps occur at T+1..T+32).
REQ-016 BY_ZERO: the block SHALL go to DONE at the next edge, with quotient = 0xFFFFFFFF and remainder = dividend as latched (raw, unsigned).
- Resulting latency: ready high after edge T+2.
REQ-017 Sign correction, applied at DONE entry:
- Quotient SHALL be negated when the signs differ.
- Remainder SHALL take the sign of the dividend.
- Arithmetic SHALL be modulo 2^32.
- Therefore 0x80000000 / 0xFFFFFFFF (signed) SHALL give quotient 0x80000000, remainder 0.
REQ-018 Unsigned operation (div_signed=0): the block SHALL apply no correction.
REQ-019 DONE: ready SHALL be 1 and result SHALL hold stable while div_start=1. When div_start=0, the block SHALL return to IDLE next cycle and clear ready and result to 0.
REQ-020 stallreq SHALL equal div_start AND NOT (state==DONE). It SHALL be 0 whenever annul=1.
REQ-021 Annul in any state SHALL force IDLE at the next edge.
- ready SHALL be cleared to 0 and result to 0.
- Annul has priority over div_start in the same cycle.
REQ-022 The block SHALL ignore operand changes after accept until IDLE is re-entered.
REQ-023 A new div_start is accepted only in IDLE. Back-to-back divides therefore require div_start to drop for at least one cycle.

Reset
REQ-024 On rst=1 at a clock edge, the block SHALL force state IDLE, clear the counter, and set result=0 and ready=0.
- rst SHALL take priority over annul and div_start.
- While rst=1, stallreq SHALL be 0.
REQ-025 Reset mid-operation (BY_ZERO, ON or DONE) SHALL discard the operation; no partial result shall become visible.

Verification
REQ-026 divu 100 / 7, start held -> ready=1 at T+33; result={0x00000002, 0x0000000E}; stallreq=1 for cycles T..T+32.
REQ-027 div -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF at T+33.
REQ-028 div 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0x00000000.
REQ-029 divu 0x12345678 / 0 -> ready at T+2; quotient 0xFFFFFFFF, remainder 0x12345678.
REQ-030 divu 0xFFFFFFFF / 1 with annul pulsed at T+10 -> IDLE at T+11; ready never asserts; stallreq=0 from T+10. A fresh start at T+12 completes at T+45.
REQ-031 rst asserted at T+20 of an ON operation -> result=0 and ready=0 after the edge; with div_start still high, a new accept occurs after rst deasserts.
